// File: rtl/tohost_pkt_fifo_pkg.sv
// Shared types and constants for the to-host packet buffer.
// The converter downstream only copes with whole beats plus a half final beat.
package tohost_pkt_fifo_pkg;

   localparam int TDATA_W = 64;
   localparam int TKEEP_W = 8;
   localparam int ENTRY_W = 73;

   localparam logic [TKEEP_W-1:0] KEEP_FULL = 8'hFF;
   localparam logic [TKEEP_W-1:0] KEEP_HALF = 8'h0F;

   typedef struct packed {
      logic               tlast;
      logic [TKEEP_W-1:0] tkeep;
      logic [TDATA_W-1:0] tdata;
   } entry_t;

   // Mid-packet beats must be full; the final beat may also be the low half.
   function automatic logic keep_illegal(input logic [TKEEP_W-1:0] keep, input logic last);
      keep_illegal = last ? ((keep != KEEP_FULL) && (keep != KEEP_HALF))
                          : (keep != KEEP_FULL);
   endfunction

endpackage

// File: rtl/tohost_pkt_ram.sv
// Simple dual-port RAM, one write port and one registered read port (1-cycle read).
// No reset on the array; validity of read data is tracked by the caller.
module tohost_pkt_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 73
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [1<<ADDR_W];

   // Read-before-write: a same-edge write to rd_addr is not visible until the next read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/tohost_pkt_fifo.sv
// 64-bit AXI-stream to-host packet buffer: accept-to-m0_tvalid latency 2 cycles, 1 beat/cycle,
// holds m0 stable under back-pressure. TOHOST_STORE_FWD_EN selects store-and-forward release.
module tohost_pkt_fifo
   import tohost_pkt_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_axis_tvalid,
   input  logic [TDATA_W-1:0]    s_axis_tdata,
   input  logic [TKEEP_W-1:0]    s_axis_tkeep,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic                  m0_axis_tohost_tvalid,
   output logic [TDATA_W-1:0]    m0_axis_tohost_tdata,
   output logic [TKEEP_W-1:0]    m0_axis_tohost_tkeep,
   output logic                  m0_axis_tohost_tlast,
   input  logic                  m0_axis_tohost_tready,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic                  err_keep,
   output logic                  err_pkt_long
);

   localparam int PTR_W = DEPTH_LOG2 + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_nxt;
   logic             rdy_en;
   logic             rd_vld;
   logic             mem_full;
   logic             in_acc;
   logic             out_acc;
   logic             out_load;
   logic             eligible;
   entry_t           in_entry;
   entry_t           rd_entry;

   assign mem_full = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

   assign s_axis_tready = rdy_en && !mem_full;
   assign in_acc        = s_axis_tvalid && s_axis_tready;
   assign out_acc       = m0_axis_tohost_tvalid && m0_axis_tohost_tready;
   assign in_entry      = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

   // The beat at rd_ptr stays counted in memory until it moves into the output register,
   // so prefetching it into the RAM read register never needs an extra slot.
   assign out_load   = rd_vld && eligible && (!m0_axis_tohost_tvalid || m0_axis_tohost_tready);
   assign rd_ptr_nxt = rd_ptr + PTR_W'(out_load);

   tohost_pkt_ram #(
      .ADDR_W (DEPTH_LOG2),
      .DATA_W (ENTRY_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (in_acc),
      .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
      .wr_data (in_entry),
      .rd_addr (rd_ptr_nxt[DEPTH_LOG2-1:0]),
      .rd_data (rd_entry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en                <= 1'b0;
         wr_ptr                <= '0;
         rd_ptr                <= '0;
         rd_vld                <= 1'b0;
         m0_axis_tohost_tvalid <= 1'b0;
         m0_axis_tohost_tdata  <= '0;
         m0_axis_tohost_tkeep  <= '0;
         m0_axis_tohost_tlast  <= 1'b0;
         fifo_count            <= '0;
         err_keep              <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (in_acc) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         rd_ptr <= rd_ptr_nxt;
         // Compared against the pre-edge write pointer: a slot written this edge reads stale.
         rd_vld <= (rd_ptr_nxt != wr_ptr);

         if (out_load) begin
            m0_axis_tohost_tvalid <= 1'b1;
            m0_axis_tohost_tdata  <= rd_entry.tdata;
            m0_axis_tohost_tkeep  <= rd_entry.tkeep;
            m0_axis_tohost_tlast  <= rd_entry.tlast;
         end else if (out_acc) begin
            m0_axis_tohost_tvalid <= 1'b0;
         end

         if (in_acc && !out_acc) begin
            fifo_count <= fifo_count + PTR_W'(1);
         end else if (!in_acc && out_acc) begin
            fifo_count <= fifo_count - PTR_W'(1);
         end

         if (in_acc && keep_illegal(s_axis_tkeep, s_axis_tlast)) begin
            err_keep <= 1'b1;
         end
      end
   end

`ifdef TOHOST_STORE_FWD_EN
   logic [PTR_W-1:0] pkt_cnt;
   logic             ct_mode;
   logic             pkt_long;
   logic             tlast_wr;
   logic             tlast_rd;

   assign tlast_wr     = in_acc && s_axis_tlast;
   assign tlast_rd     = out_load && rd_entry.tlast;
   assign eligible     = (pkt_cnt != '0) || ct_mode;
   assign err_pkt_long = pkt_long;

   // A full memory with no complete packet can never make progress, so the packet
   // at the head is released cut-through until its tlast has left memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt  <= '0;
         ct_mode  <= 1'b0;
         pkt_long <= 1'b0;
      end else begin
         if (tlast_wr && !tlast_rd) begin
            pkt_cnt <= pkt_cnt + PTR_W'(1);
         end else if (!tlast_wr && tlast_rd) begin
            pkt_cnt <= pkt_cnt - PTR_W'(1);
         end

         if (mem_full && (pkt_cnt == '0) && !ct_mode) begin
            ct_mode  <= 1'b1;
            pkt_long <= 1'b1;
         end else if (ct_mode && tlast_rd) begin
            ct_mode <= 1'b0;
         end
      end
   end
`else
   assign eligible     = 1'b1;
   assign err_pkt_long = 1'b0;
`endif

endmodule

// File: tb/tb_tohost_pkt_fifo.sv
// Bench for tohost_pkt_fifo: queue scoreboard, tkeep vector table, fill/reset/random sequences.
`timescale 1ns/1ps
module tb_tohost_pkt_fifo;

   localparam int DL2   = 9;
   localparam int DEPTH = 1 << DL2;
   localparam int CAP   = DEPTH + 1;
   localparam int NRAND = 10000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        s_tvalid = 1'b0;
   logic [63:0] s_tdata = '0;
   logic [7:0]  s_tkeep = '0;
   logic        s_tlast = 1'b0;
   logic        s_tready;
   logic        m_tvalid;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;
   logic        m_tlast;
   logic        m_tready = 1'b0;
   logic [DL2:0] fifo_count;
   logic        err_keep;
   logic        err_pkt_long;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_out = 0;
   logic [72:0] model_q[$];

   always #5 clk = ~clk;

   tohost_pkt_fifo #(.DEPTH_LOG2(DL2)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .s_axis_tvalid         (s_tvalid),
      .s_axis_tdata          (s_tdata),
      .s_axis_tkeep          (s_tkeep),
      .s_axis_tlast          (s_tlast),
      .s_axis_tready         (s_tready),
      .m0_axis_tohost_tvalid (m_tvalid),
      .m0_axis_tohost_tdata  (m_tdata),
      .m0_axis_tohost_tkeep  (m_tkeep),
      .m0_axis_tohost_tlast  (m_tlast),
      .m0_axis_tohost_tready (m_tready),
      .fifo_count            (fifo_count),
      .err_keep              (err_keep),
      .err_pkt_long          (err_pkt_long)
   );

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired", name);
   endtask

   // One clock: score handshakes seen before the edge, then check the post-edge state.
   task automatic cycle();
      logic        in_acc;
      logic        out_acc;
      logic        stall;
      logic [72:0] got;
      logic [72:0] exp;
      in_acc  = s_tvalid && s_tready;
      out_acc = m_tvalid && m_tready;
      stall   = m_tvalid && !m_tready;
      got     = {m_tlast, m_tkeep, m_tdata};
      if (out_acc) begin
         n_out++;
         if (model_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got %0h expected no beat", got);
         end else begin
            exp = model_q.pop_front();
            chk("out_beat", got, exp);
         end
      end
      if (in_acc) model_q.push_back({s_tlast, s_tkeep, s_tdata});
      @(posedge clk);
      #1;
      cyc++;
      chk("fifo_count", fifo_count, model_q.size());
      chk("count_le_max", fifo_count <= CAP, 1);
      if (fifo_count < DEPTH) chk("tready_open", s_tready, 1);
      if (stall) chk("stall_hold", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, got});
   endtask

   task automatic do_reset();
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_beat", {m_tlast, m_tkeep, m_tdata}, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_err_keep", err_keep, 0);
      chk("rst_err_pkt_long", err_pkt_long, 0);
      model_q.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1 chk("tready_before_first_edge", s_tready, 0);
      @(posedge clk);
      #1;
      chk("tready_after_release", s_tready, 1);
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
      bit done;
      done = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
      for (int i = 0; i < 2000 && !done; i++) begin
         done = s_tready;
         cycle();
      end
      s_tvalid = 1'b0;
      if (!done) fail("send_timeout");
   endtask

   task automatic drain();
      m_tready = 1'b1;
      for (int i = 0; i < 3000 && fifo_count != 0; i++) cycle();
      cycle();
      chk("drain_empty", fifo_count, 0);
   endtask

   typedef struct {
      bit         rst;
      logic [7:0] keep;
      bit         last;
      bit         exp_err;
   } kv_t;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      kv_t         kv[11];
      bit          acc;
      bit          seen_full;
      bit          have;
      int          sent;
      int          first_acc;
      int          first_vld;
      int          plen;
      int          pos;
      logic        last;
      logic [7:0]  keep;
      logic [72:0] cur;

      kv[0]  = '{1'b1, 8'hFF, 1'b0, 1'b0};
      kv[1]  = '{1'b0, 8'hFF, 1'b1, 1'b0};
      kv[2]  = '{1'b0, 8'h0F, 1'b1, 1'b0};
      kv[3]  = '{1'b0, 8'h3F, 1'b0, 1'b1};
      kv[4]  = '{1'b0, 8'hFF, 1'b1, 1'b1};
      kv[5]  = '{1'b1, 8'h0F, 1'b0, 1'b1};
      kv[6]  = '{1'b1, 8'h07, 1'b1, 1'b1};
      kv[7]  = '{1'b1, 8'hFF, 1'b1, 1'b0};
      kv[8]  = '{1'b1, 8'h00, 1'b1, 1'b1};
      kv[9]  = '{1'b1, 8'hF0, 1'b1, 1'b1};
      kv[10] = '{1'b1, 8'h0F, 1'b1, 1'b0};

      #2;
      do_reset();

      // Single 4-beat packet, sink always ready.
      m_tready  = 1'b1;
      n_out     = 0;
      first_acc = -1;
      first_vld = -1;
      for (int i = 0; i < 14; i++) begin
         s_tvalid = (i < 4);
         s_tdata  = 64'h1111_1111_1111_1111 * (i + 1);
         s_tkeep  = 8'hFF;
         s_tlast  = (i == 3);
         acc = s_tvalid && s_tready;
         cycle();
         if (acc && first_acc < 0) first_acc = cyc;
         if (m_tvalid && first_vld < 0) first_vld = cyc;
      end
      s_tvalid = 1'b0;
`ifndef TOHOST_STORE_FWD_EN
      chk("first_beat_latency", first_vld - first_acc, 2);
`endif
      chk("pkt4_out_count", n_out, 4);
      chk("pkt4_count_zero", fifo_count, 0);

      // tkeep legality table.
      foreach (kv[i]) begin
         if (kv[i].rst) do_reset();
         m_tready = 1'b1;
         send_beat({32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)}, kv[i].keep, kv[i].last);
`ifdef TOHOST_STORE_FWD_EN
         if (kv[i].last) drain();
`else
         drain();
`endif
         chk($sformatf("err_keep_row%0d", i), err_keep, kv[i].exp_err);
      end

      // Fill against a stalled sink.
      do_reset();
      m_tready  = 1'b0;
      sent      = 0;
      seen_full = 1'b0;
      n_out     = 0;
      for (int c = 0; c < 620; c++) begin
         s_tvalid = (sent < 600);
         s_tdata  = 64'hF000_0000_0000_0000 | 64'(sent);
         s_tkeep  = 8'hFF;
         s_tlast  = (sent == 599);
         if (!s_tready && !seen_full) begin
            seen_full = 1'b1;
`ifdef TOHOST_STORE_FWD_EN
            chk("sf_first_full_count", fifo_count, DEPTH);
            chk("sf_err_long_before", err_pkt_long, 0);
`else
            chk("full_count", fifo_count, CAP);
`endif
         end
         acc = s_tvalid && s_tready;
         cycle();
         if (acc) sent++;
      end
      chk("seen_full", seen_full, 1);
      chk("fill_accepted", sent, CAP);
      chk("fill_count", fifo_count, CAP);
`ifdef TOHOST_STORE_FWD_EN
      chk("sf_err_pkt_long", err_pkt_long, 1);
      m_tready = 1'b1;
      for (int c = 0; c < 2000 && sent < 600; c++) begin
         s_tvalid = 1'b1;
         s_tdata  = 64'hF000_0000_0000_0000 | 64'(sent);
         s_tlast  = (sent == 599);
         acc = s_tready;
         cycle();
         if (acc) sent++;
      end
      s_tvalid = 1'b0;
      drain();
      chk("sf_long_out_count", n_out, 600);
      chk("sf_err_pkt_long_sticky", err_pkt_long, 1);
`else
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      cycle();
      chk("tready_reopen", s_tready, 1);
      drain();
      chk("fill_out_count", n_out, CAP);
`endif

`ifdef TOHOST_STORE_FWD_EN
      // Store-and-forward holds an incomplete packet.
      do_reset();
      m_tready = 1'b1;
      n_out    = 0;
      send_beat(64'hAAAA_0000_0000_0001, 8'hFF, 1'b0);
      send_beat(64'hAAAA_0000_0000_0002, 8'hFF, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("sf_hold_tvalid", m_tvalid, 0);
      end
      send_beat(64'hAAAA_0000_0000_0003, 8'h0F, 1'b1);
      drain();
      chk("sf_pkt3_out_count", n_out, 3);
`endif

      // Random traffic against the queue model.
      do_reset();
      n_out = 0;
      sent  = 0;
      have  = 1'b0;
      pos   = 0;
      plen  = 1;
      cur   = '0;
      for (int c = 0; c < 60000 && (sent < NRAND || fifo_count != 0); c++) begin
         if (!have && sent < NRAND) begin
            if (pos == 0) plen = $urandom_range(1, 64);
            pos++;
            last = (pos == plen) || (sent == NRAND - 1);
            keep = (last && $urandom_range(0, 1) == 1) ? 8'h0F : 8'hFF;
            cur  = {last, keep, $urandom, $urandom};
            if (last) pos = 0;
            have = 1'b1;
         end
         s_tvalid = have && ($urandom_range(0, 1) == 1);
         {s_tlast, s_tkeep, s_tdata} = cur;
         m_tready = ($urandom_range(0, 1) == 1);
         acc = s_tvalid && s_tready;
         cycle();
         if (acc) begin
            have = 1'b0;
            sent++;
         end
      end
      s_tvalid = 1'b0;
      chk("rand_sent", sent, NRAND);
      chk("rand_out", n_out, NRAND);
      chk("rand_drained", fifo_count, 0);
      chk("rand_err_keep", err_keep, 0);
      chk("rand_err_pkt_long", err_pkt_long, 0);

      // Reset with 20 beats buffered, then a fresh packet.
      do_reset();
      m_tready = 1'b0;
      for (int i = 0; i < 20; i++) send_beat(64'hDEAD_0000_0000_0000 | 64'(i), 8'hFF, 1'b0);
      cycle();
      chk("buffered_20", fifo_count, 20);
      do_reset();
      m_tready = 1'b1;
      n_out    = 0;
      send_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
      send_beat(64'hFEDC_BA98_7654_3210, 8'h0F, 1'b1);
      drain();
      chk("post_reset_out_count", n_out, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tohost_pkt_fifo.md
Name: tohost_pkt_fifo

Overview:
- 64-bit AXI-stream packet buffer on the to-host path.
- Accepts beats from user logic and feeds them to the 64-to-32 DMA width converter.
- Absorbs DMA back-pressure and checks tkeep legality: the converter only handles whole 8'hFF beats, plus an 8'h0F final beat.
- Reports occupancy and sticky error flags to the register block.

Parameters:
- DEPTH_LOG2, 9, log2 of the number of buffer entries (DEPTH = 512 beats).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tvalid  in  1  upstream beat valid
- s_axis_tdata  in  64  upstream data
- s_axis_tkeep  in  8  upstream byte enables
- s_axis_tlast  in  1  upstream end of packet
- s_axis_tready  out  1  buffer can accept a beat
- m0_axis_tohost_tvalid  out  1  beat valid to converter
- m0_axis_tohost_tdata  out  64  data to converter
- m0_axis_tohost_tkeep  out  8  byte enables to converter
- m0_axis_tohost_tlast  out  1  end of packet to converter
- m0_axis_tohost_tready  in  1  converter accepts the beat
- fifo_count  out  DEPTH_LOG2+1  beats held, including the output register
- err_keep  out  1  sticky: illegal tkeep seen
- err_pkt_long  out  1  sticky: store-and-forward overrun (macro builds only; tied 0 otherwise)

Behaviour:
- Reset (asynchronous, active-low): every output register goes to 0.
  - Pointers, counters and flags cleared.
  - s_axis_tready = 0 during reset and 1 from the first clock edge after release.
  - Reset mid-packet discards all buffered data; there is no partial-packet recovery.
- Storage:
  - DEPTH x 73-bit entries {tlast, tkeep, tdata}.
  - Synchronous-read memory.
  - Write and read pointers are DEPTH_LOG2+1 bits and wrap naturally; full/empty is decided by the MSB compare.
- Input handshake:
  - A beat is stored on an edge with s_axis_tvalid && s_axis_tready.
  - s_axis_tready = !mem_full (combinational from registered pointers).
  - When full, a simultaneous read does not open tready in the same cycle; it rises on the next cycle.
- Output stage:
  - One output register holds the beat presented on m0_*.
  - It reloads from memory when it is empty, or when m0_axis_tohost_tvalid && m0_axis_tohost_tready, and memory holds an eligible beat.
  - m0_* are stable while tvalid=1 and tready=0.
  - Back-to-back throughput is 1 beat/cycle.
- Latency: a beat accepted at edge N into an empty buffer shows m0_axis_tohost_tvalid=1 after edge N+2.
- fifo_count: +1 per accepted input beat, -1 per accepted output beat; both in the same cycle leaves it unchanged. Maximum value is DEPTH+1.
- tkeep check, applied to each accepted input beat:
  - A beat with tlast=0 and tkeep!=8'hFF sets err_keep.
  - A beat with tlast=1 and tkeep not in {8'hFF, 8'h0F} sets err_keep.
  - The offending beat is still stored and forwarded unchanged.
  - err_keep clears only on reset.
- No drops: data is never discarded while rst_n=1.

Optional Feature:
- Macro TOHOST_STORE_FWD_EN.
- Defined:
  - A complete-packet counter increments when a tlast beat is written and decrements when a tlast beat leaves memory for the output register.
  - A beat is eligible only when this counter is >0.
  - Exception: if memory is full and the counter is 0, set err_pkt_long and release the current packet in cut-through until its tlast leaves memory, then resume store-and-forward.
  - A tlast write and a tlast read in the same cycle leave the counter unchanged.
- Undefined: cut-through; every stored beat is eligible immediately, and err_pkt_long is tied 0.

Decomposition:
- Shared package: ENTRY_W=73, TDATA_W=64, TKEEP_W=8, constants KEEP_FULL=8'hFF and KEEP_HALF=8'h0F.
- One sub-module, tohost_pkt_ram: simple dual-port synchronous-read RAM, parameterised by depth and width.
- Control, output register and checks stay in the top.

Test Plan:
- Single 4-beat packet, data 0x1111..–0x4444.., last tkeep 8'hFF, sink always ready -> out beats identical and in order; first out tvalid 2 cycles after first accept; fifo_count returns to 0.
- Fill with tready=0 for 600 beats offered -> s_axis_tready drops when fifo_count=513; release sink -> all 513 beats drain in order; tready reasserts the cycle after the first read.
- Last beat tkeep 8'h0F, then a mid-packet beat with tkeep 8'h3F -> both forwarded unchanged; err_keep=0 after the first, err_keep=1 after the second and still 1 at end; cleared by reset.
- Random tvalid/tready at 50% each, 10k beats across packets of 1–64 beats -> scoreboard exact match; fifo_count never exceeds 513; no output change while stalled.
- Reset asserted mid-packet with 20 beats buffered -> all outputs 0 immediately; after release, a new 2-beat packet passes intact with no stale data.
- TOHOST_STORE_FWD_EN build: a 3-beat packet is held with m0 tvalid=0 until tlast is written; a 600-beat packet sets err_pkt_long at full and then drains completely.
